// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: single-cycle core writeback has priority, and
// long-latency results queue in a small FIFO. The arbiter stalls the core on hazards or starvation.
module wb_port_arbiter #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        pri_we,
  input  logic [4:0]                  pri_nd,
  input  logic [DATA_W-1:0]           pri_data,
  input  logic                        sec_valid,
  output logic                        sec_ready,
  input  logic [4:0]                  sec_nd,
  input  logic [DATA_W-1:0]           sec_data,
  input  logic [4:0]                  rs_addr,
  input  logic [4:0]                  rt_addr,
  output logic                        rf_we,
  output logic [4:0]                  rf_wa,
  output logic [DATA_W-1:0]           rf_wd,
  output logic                        stall,
  output logic [$clog2(DEPTH):0]      pending_cnt
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  logic [4:0]        nd_mem   [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [WAIT_W-1:0] wait_cnt;

  logic empty, full, hazard, starve, pri_sel, pop, push;
  logic [PTR_W-1:0] idx;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

  // Any queued result targeting a register the current instruction reads or
  // overwrites must land first, so ordering matches program order.
  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no latch is inferred.
    hazard = 1'b0;
    idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count) && (nd_mem[idx] != 5'd0) &&
          ((nd_mem[idx] == rs_addr) || (nd_mem[idx] == rt_addr) ||
           (pri_we && (nd_mem[idx] == pri_nd))))
        hazard = 1'b1;
    end
  end

  assign starve    = !empty && (wait_cnt >= WAIT_W'(MAX_WAIT));
  assign stall     = !rst && (hazard || starve);
  assign pri_sel   = !rst && !stall && pri_we && (pri_nd != 5'd0);
  assign pop       = !rst && !pri_sel && !empty;
  // Readiness comes from registered occupancy only; a same-cycle pop never frees a slot early.
  assign sec_ready = !rst && !full;
  assign push      = sec_valid && sec_ready && (sec_nd != 5'd0);

  always_comb begin
    rf_we = 1'b0;
    rf_wa = 5'd0;
    rf_wd = '0;
    if (pri_sel) begin
      rf_we = 1'b1;
      rf_wa = pri_nd;
      rf_wd = pri_data;
    end else if (pop) begin
      rf_we = 1'b1;
      rf_wa = nd_mem[rd_ptr];
      rf_wd = data_mem[rd_ptr];
    end
  end

  // NOTE: storage is deliberately not reset; occupancy gates every read, so stale
  // contents are never observed and the array maps onto plain registers/RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      nd_mem[wr_ptr]   <= sec_nd;
      data_mem[wr_ptr] <= sec_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      wait_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (empty || pop)
        wait_cnt <= '0;
      else if (wait_cnt != WAIT_W'(MAX_WAIT))
        wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  assign pending_cnt = count;

endmodule
